key_matrix_scan: RTL and testbench
==================================

// Module: key_matrix_scan
// PURPOSE
//  Input-side counterpart of the LED column scanner: drives one-cold column strobes into a
//  4x8 key/button matrix, samples the 8 active-low row returns, and debounces every key.
//  Publishes the 32-bit debounced key map and a press/release event stream through a
//  valid/ready handshake backed by a small FIFO. Sits between board pins and the CPU bus.
// PARAMETERS
//  DWELL_BITS      12  column dwell = 2**DWELL_BITS clk cycles; full scan = 4x that
//  SETTLE_CYCLES   16  dwell offset at which rows are sampled (> 2-flop sync + pin settle)
//  DEBOUNCE_SCANS   8  consecutive disagreeing samples (1..15) needed to flip a key
//  EVT_DEPTH        4  event FIFO entries (power of 2, >=2)
// PORTS
//  clk12MHz     in   1   system clock
//  resetn       in   1   async active-low reset
//  row_in       in   8   matrix rows, active-low, externally pulled up
//  col_out      out  4   column strobes, one-cold (0 = column driven)
//  keys         out  32  debounced state, bit = col*8+row, 1 = pressed
//  evt_valid    out  1   event available at FIFO head
//  evt_ready    in   1   consumer accepts head event
//  evt_code     out  5   key index of head event
//  evt_press    out  1   1 = press, 0 = release
//  evt_overflow out  1   sticky: an unreported change was lost
//  ovf_clr      in   1   single-cycle clear of evt_overflow
// BEHAVIOUR
//  - Reset: timer=0, col_out=4'b1110, keys=0, debounce counters=0, pending=0, FIFO empty,
//    evt_valid=0, evt_code=0, evt_press=0, evt_overflow=0; row sync flops reset to 8'hFF.
//  - Scan timer (DWELL_BITS+2 bits) free-runs, wraps 4x2**DWELL_BITS-1 -> 0. col = timer MSBs;
//    col_out = ~(1<<col), registered, changes exactly on dwell boundary.
//  - row_in passes a 2-flop synchroniser. Sample strobe: dwell bits == SETTLE_CYCLES, once
//    per column per scan. raw[r] = ~row_sync[r] for key col*8+r.
//  - Debounce (8 keys updated in parallel on strobe): raw==keys[k] -> cnt[k]=0; else
//    cnt[k]+1; at cnt == DEBOUNCE_SCANS-1 increment: keys[k] toggles, cnt[k]=0, flip event.
//    keys latency: press seen from DEBOUNCE_SCANS-th disagreeing sample, +1 clk.
//  - Pending bits (32): flip sets pending[k]; flip while pending[k] already set clears it
//    (net change zero) and sets evt_overflow.
//  - Arbiter: each cycle, lowest-index pending key pushed to FIFO if FIFO can accept;
//    entry = {keys[k], k}; pending[k] cleared same cycle. FIFO full -> pending held, no loss.
//    Flip and push of same key in same cycle: flip wins (push suppressed, rules above apply).
//  - Handshake: evt_valid = FIFO non-empty; transfer on valid&&ready; head stable while
//    valid&&!ready. Full + pop + push same cycle: both occur. Empty + ready: no effect.
//  - evt_overflow: set has priority over ovf_clr in same cycle.
//  - Reset mid-scan/mid-debounce: all state discarded, no events emitted for held keys
//    until they debounce afresh from keys=0.
// STRUCTURE
//  - key_scan_pkg: NCOLS=4, NROWS=8, KEY_IDX_W=5, key-event record {press, code[4:0]},
//    one-cold column decode function.
//  - Sub-module key_event_fifo (width 6, depth EVT_DEPTH, count-based full/empty, async
//    active-low reset). Top holds timer, sync, debounce array, pending, arbiter.
// TESTING (DWELL_BITS=4, SETTLE_CYCLES=3, DEBOUNCE_SCANS=2, EVT_DEPTH=4)
//  1 Reset, rows all 1 -> col_out walks 1110,1101,1011,0111 every 16 clk; keys=0, no evt.
//  2 Hold row2 low during col1 for 2 scans -> keys[10]=1; one event code=10 press=1;
//    release 2 scans -> code=10 press=0.
//  3 Row glitch low for 1 scan only -> keys unchanged, no event, counter back to 0.
//  4 Press 8 keys of col3 simultaneously, evt_ready=0 -> 4 events (24..27) queued, 28..31
//    pending; raise ready -> 8 events in index order, none lost, evt_overflow=0.
//  5 ready=0, press then release key 0 before drain with FIFO full -> pending cleared,
//    evt_overflow=1; ovf_clr pulse -> 0.
//  6 Assert resetn=0 mid-dwell with keys held -> all outputs reset values; after release,
//    press events re-emitted after 2 scans.

Source files
------------

// File: rtl/key_scan_pkg.sv
// Shared types and helpers for the key matrix scanner.
// Matrix geometry, key-event record and column strobe decode.
package key_scan_pkg;

    localparam int NCOLS     = 4;
    localparam int NROWS     = 8;
    localparam int NKEYS     = NCOLS * NROWS;
    localparam int KEY_IDX_W = 5;

    typedef struct packed {
        logic                 press;
        logic [KEY_IDX_W-1:0] code;
    } key_evt_t;

    // One-cold strobe: the driven column is the only 0.
    function automatic logic [NCOLS-1:0] col_onecold(
        input logic [1:0] col
    );
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small count-based FIFO holding key events.
// Ports: i_clk, i_rst_n (async low), i_push/i_din, i_pop,
//        o_dout (head), o_empty, o_full.
module key_event_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_empty,
    output logic         o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    logic w_pop;
    logic w_push;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_dout  = r_mem[r_rp];

    // A push into a full FIFO is legal when a pop frees a slot.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_din;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/key_matrix_scan.sv
// 4x8 key matrix scanner with per-key debounce and event stream.
// Ports: clk12MHz, resetn (async low), row_in[8] (active low),
//        col_out[4] (one-cold), keys[32], evt_valid/evt_ready,
//        evt_code[5], evt_press, evt_overflow (sticky), ovf_clr.
module key_matrix_scan
    import key_scan_pkg::*;
#(
    parameter int DWELL_BITS     = 12,
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 8,
    parameter int EVT_DEPTH      = 4
) (
    input  logic                 clk12MHz,
    input  logic                 resetn,
    input  logic [NROWS-1:0]     row_in,
    output logic [NCOLS-1:0]     col_out,
    output logic [NKEYS-1:0]     keys,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [KEY_IDX_W-1:0] evt_code,
    output logic                 evt_press,
    output logic                 evt_overflow,
    input  logic                 ovf_clr
);

    localparam int TW = DWELL_BITS + 2;
    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_SCANS - 1);

    logic [TW-1:0]         r_timer;
    logic [NCOLS-1:0]      r_col_out;
    logic [NROWS-1:0]      r_sync1;
    logic [NROWS-1:0]      r_sync2;
    logic [NKEYS-1:0]      r_keys;
    logic [3:0]            r_cnt [NKEYS];
    logic [NKEYS-1:0]      r_pend;
    logic                  r_ovf;

    logic [TW-1:0]         w_timer_nxt;
    logic [1:0]            w_col;
    logic [1:0]            w_col_nxt;
    logic                  w_strobe;
    logic [NROWS-1:0]      w_raw;
    logic [NKEYS-1:0]      w_keys_nxt;
    logic [3:0]            w_cnt_nxt [NKEYS];
    logic [NKEYS-1:0]      w_flip;
    logic [NKEYS-1:0]      w_cand;
    logic [KEY_IDX_W-1:0]  w_sel;
    logic                  w_any;
    logic                  w_push;
    logic                  w_pop;
    logic [NKEYS-1:0]      w_pend_nxt;
    logic                  w_ovf_set;
    logic                  w_empty;
    logic                  w_full;
    key_evt_t              w_push_evt;
    key_evt_t              w_head;

    assign w_timer_nxt = r_timer + TW'(1);
    assign w_col       = r_timer[TW-1 -: 2];
    assign w_col_nxt   = w_timer_nxt[TW-1 -: 2];
    assign w_strobe    = (r_timer[DWELL_BITS-1:0]
                          == DWELL_BITS'(SETTLE_CYCLES));
    assign w_raw       = ~r_sync2;

    // Debounce: only the keys of the driven column see the strobe.
    always_comb begin
        w_keys_nxt = r_keys;
        w_flip     = '0;
        for (int k = 0; k < NKEYS; k++) begin
            w_cnt_nxt[k] = r_cnt[k];
        end
        if (w_strobe) begin
            for (int k = 0; k < NKEYS; k++) begin
                if (w_col == 2'(k / NROWS)) begin
                    if (w_raw[k % NROWS] == r_keys[k]) begin
                        w_cnt_nxt[k] = '0;
                    end else if (r_cnt[k] == CNT_MAX) begin
                        w_keys_nxt[k] = ~r_keys[k];
                        w_cnt_nxt[k]  = '0;
                        w_flip[k]     = 1'b1;
                    end else begin
                        w_cnt_nxt[k] = r_cnt[k] + 4'd1;
                    end
                end
            end
        end
    end

    // A key flipping this cycle is excluded so the flip rules win.
    always_comb begin
        w_cand = r_pend & ~w_flip;
        w_sel  = '0;
        w_any  = 1'b0;
        for (int k = NKEYS - 1; k >= 0; k--) begin
            if (w_cand[k]) begin
                w_sel = KEY_IDX_W'(k);
                w_any = 1'b1;
            end
        end
    end

    assign w_pop  = evt_valid && evt_ready;
    assign w_push = w_any && (!w_full || w_pop);

    assign w_push_evt.press = r_keys[w_sel];
    assign w_push_evt.code  = w_sel;

    // A second flip on a pending key cancels it: net change is zero.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_push) begin
            w_pend_nxt[w_sel] = 1'b0;
        end
        w_pend_nxt = w_pend_nxt ^ w_flip;
        w_ovf_set  = |(r_pend & w_flip);
    end

    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) begin
            r_timer   <= '0;
            r_col_out <= 4'b1110;
            r_sync1   <= '1;
            r_sync2   <= '1;
            r_keys    <= '0;
            r_pend    <= '0;
            r_ovf     <= 1'b0;
            for (int k = 0; k < NKEYS; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_timer   <= w_timer_nxt;
            r_col_out <= col_onecold(w_col_nxt);
            r_sync1   <= row_in;
            r_sync2   <= r_sync1;
            r_keys    <= w_keys_nxt;
            r_pend    <= w_pend_nxt;
            for (int k = 0; k < NKEYS; k++) begin
                r_cnt[k] <= w_cnt_nxt[k];
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    key_event_fifo #(
        .W     ($bits(key_evt_t)),
        .DEPTH (EVT_DEPTH)
    ) u_fifo (
        .i_clk   (clk12MHz),
        .i_rst_n (resetn),
        .i_push  (w_push),
        .i_din   (w_push_evt),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign col_out      = r_col_out;
    assign keys         = r_keys;
    assign evt_valid    = !w_empty;
    assign evt_code     = w_head.code;
    assign evt_press    = w_head.press;
    assign evt_overflow = r_ovf;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan with a behavioural key matrix.
// Dwell 16 clk, settle 3, debounce 2 scans, 4-entry event FIFO.
module tb_key_matrix_scan;

    logic        clk;
    logic        resetn;
    logic [7:0]  row_in;
    logic [3:0]  col_out;
    logic [31:0] keys;
    logic        evt_valid;
    logic        evt_ready;
    logic [4:0]  evt_code;
    logic        evt_press;
    logic        evt_overflow;
    logic        ovf_clr;

    logic [31:0] pressed;

    int total = 0;
    int bad   = 0;

    localparam int SCAN = 64;

    key_matrix_scan #(
        .DWELL_BITS     (4),
        .SETTLE_CYCLES  (3),
        .DEBOUNCE_SCANS (2),
        .EVT_DEPTH      (4)
    ) dut (
        .clk12MHz     (clk),
        .resetn       (resetn),
        .row_in       (row_in),
        .col_out      (col_out),
        .keys         (keys),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_press    (evt_press),
        .evt_overflow (evt_overflow),
        .ovf_clr      (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed switch pulls its row low while its column is driven.
    always_comb begin
        row_in = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            if (!col_out[c]) begin
                row_in = row_in & ~pressed[c*8 +: 8];
            end
        end
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_scans(input int n);
        repeat (n * SCAN) @(negedge clk);
    endtask

    task automatic pop_expect(input string nm,
                              input int code,
                              input logic press);
        int n;
        n = 0;
        while (!evt_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, 32'(evt_valid), 32'd1);
        if (evt_valid) begin
            chk({nm, "_code"}, 32'(evt_code), 32'(code));
            chk({nm, "_press"}, 32'(evt_press), 32'(press));
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
        end
    endtask

    typedef struct {
        int         cyc;
        logic [3:0] col;
    } cvec_t;

    typedef struct {
        int          key;
        logic [31:0] keys_on;
    } kvec_t;

    cvec_t cv[8];
    kvec_t kv[4];

    initial begin
        cv[0] = '{0,  4'b1110};
        cv[1] = '{15, 4'b1110};
        cv[2] = '{16, 4'b1101};
        cv[3] = '{31, 4'b1101};
        cv[4] = '{32, 4'b1011};
        cv[5] = '{48, 4'b0111};
        cv[6] = '{63, 4'b0111};
        cv[7] = '{64, 4'b1110};

        kv[0] = '{10, 32'h0000_0400};
        kv[1] = '{0,  32'h0000_0001};
        kv[2] = '{17, 32'h0002_0000};
        kv[3] = '{31, 32'h8000_0000};

        resetn    = 1'b0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        pressed   = '0;
        repeat (3) @(negedge clk);

        // Reset values and column walk.
        chk("rst_col", 32'(col_out), 32'hE);
        chk("rst_keys", keys, 32'h0);
        chk("rst_valid", 32'(evt_valid), 32'h0);
        chk("rst_code", 32'(evt_code), 32'h0);
        chk("rst_press", 32'(evt_press), 32'h0);
        chk("rst_ovf", 32'(evt_overflow), 32'h0);
        resetn = 1'b1;
        begin
            int now;
            now = 0;
            for (int i = 0; i < 8; i++) begin
                while (now < cv[i].cyc) begin
                    @(negedge clk);
                    now++;
                end
                chk($sformatf("walk_%0d", cv[i].cyc),
                    32'(col_out), 32'(cv[i].col));
            end
        end
        chk("idle_keys", keys, 32'h0);
        chk("idle_valid", 32'(evt_valid), 32'h0);

        // Single-key press and release vectors.
        for (int i = 0; i < 4; i++) begin
            pressed[kv[i].key] = 1'b1;
            wait_scans(3);
            chk($sformatf("k%0d_on", kv[i].key), keys, kv[i].keys_on);
            pop_expect($sformatf("k%0d_pevt", kv[i].key),
                       kv[i].key, 1'b1);
            pressed[kv[i].key] = 1'b0;
            wait_scans(3);
            chk($sformatf("k%0d_off", kv[i].key), keys, 32'h0);
            pop_expect($sformatf("k%0d_revt", kv[i].key),
                       kv[i].key, 1'b0);
            chk($sformatf("k%0d_drained", kv[i].key),
                32'(evt_valid), 32'h0);
        end

        // One-scan glitch twice: counter must restart each time.
        for (int g = 0; g < 2; g++) begin
            pressed[10] = 1'b1;
            repeat (SCAN) @(negedge clk);
            pressed[10] = 1'b0;
            wait_scans(2);
            chk($sformatf("glitch%0d_keys", g), keys, 32'h0);
            chk($sformatf("glitch%0d_valid", g), 32'(evt_valid), 32'h0);
        end

        // Whole column 3 at once with consumer stalled.
        pressed = 32'hFF00_0000;
        wait_scans(3);
        chk("col3_keys", keys, 32'hFF00_0000);
        chk("col3_head", 32'(evt_code), 32'd24);
        chk("col3_ovf", 32'(evt_overflow), 32'h0);
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("col3_v%0d", i), 32'(evt_valid), 32'h1);
            chk($sformatf("col3_c%0d", i), 32'(evt_code), 32'(24 + i));
            chk($sformatf("col3_p%0d", i), 32'(evt_press), 32'h1);
            @(negedge clk);
        end
        chk("col3_empty", 32'(evt_valid), 32'h0);
        evt_ready = 1'b0;
        chk("col3_ovf2", 32'(evt_overflow), 32'h0);
        pressed = '0;
        wait_scans(3);
        for (int i = 0; i < 8; i++) begin
            pop_expect($sformatf("col3_rel%0d", i), 24 + i, 1'b0);
        end

        // Press/release of key 0 lost behind a full FIFO.
        pressed = 32'h0F00_0000;
        wait_scans(3);
        chk("full_head", 32'(evt_code), 32'd24);
        pressed[0] = 1'b1;
        wait_scans(3);
        chk("k0_held_keys", keys, 32'h0F00_0001);
        chk("k0_held_head", 32'(evt_code), 32'd24);
        chk("k0_held_ovf", 32'(evt_overflow), 32'h0);
        pressed[0] = 1'b0;
        wait_scans(3);
        chk("k0_lost_keys", keys, 32'h0F00_0000);
        chk("k0_lost_ovf", 32'(evt_overflow), 32'h1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(evt_overflow), 32'h0);
        for (int i = 0; i < 4; i++) begin
            pop_expect($sformatf("full_ev%0d", i), 24 + i, 1'b1);
        end
        wait_scans(1);
        chk("no_k0_evt", 32'(evt_valid), 32'h0);
        pressed = '0;
        wait_scans(3);
        for (int i = 0; i < 4; i++) begin
            pop_expect($sformatf("full_rel%0d", i), 24 + i, 1'b0);
        end

        // Reset mid-dwell with keys held.
        pressed = 32'h0002_0020;
        wait_scans(3);
        chk("pre_rst_keys", keys, 32'h0002_0020);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_col", 32'(col_out), 32'hE);
        chk("mid_rst_keys", keys, 32'h0);
        chk("mid_rst_valid", 32'(evt_valid), 32'h0);
        chk("mid_rst_code", 32'(evt_code), 32'h0);
        chk("mid_rst_press", 32'(evt_press), 32'h0);
        chk("mid_rst_ovf", 32'(evt_overflow), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (60) @(negedge clk);
        chk("post_rst_1scan", keys, 32'h0);
        pop_expect("rst_re5", 5, 1'b1);
        pop_expect("rst_re17", 17, 1'b1);
        chk("post_rst_keys", keys, 32'h0002_0020);
        pressed = '0;
        wait_scans(3);
        pop_expect("rst_rel5", 5, 1'b0);
        pop_expect("rst_rel17", 17, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
